// File: rtl/aes_host_bridge_if.sv
// Signal bundle between the host/bench and aes_host_bridge.
// Host side: in_* job word stream and out_* result word stream (valid/ready).
// Core side: key/data/start outputs to the AES core and results/ready strobes back.
// slave  : seen from the bridge.
// master : seen from whoever drives the host stream and models the core.
interface aes_host_bridge_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         err_timeout;
  logic [127:0] plain_text_in;
  logic [127:0] cipher_text_in;
  logic [127:0] cipher_key_in;
  logic [127:0] round_key_10;
  logic         cipher_new_en;
  logic         EN;
  logic [127:0] cipher_text_out;
  logic [127:0] plain_text_out;
  logic         cipher_ready;
  logic         decipher_ready;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
           cipher_text_out, plain_text_out, cipher_ready, decipher_ready,
    output in_ready, out_valid, out_data, out_last, err_timeout,
           plain_text_in, cipher_text_in, cipher_key_in, round_key_10,
           cipher_new_en, EN
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready,
           cipher_text_out, plain_text_out, cipher_ready, decipher_ready,
    input  in_ready, out_valid, out_data, out_last, err_timeout,
           plain_text_in, cipher_text_in, cipher_key_in, round_key_10,
           cipher_new_en, EN
  );
endinterface

// File: rtl/aes_host_bridge.sv
// Word-serial host front-end for the AES-128 core.
// Collects 8 job words (key[127:0] then data[127:0], MS word first), fires a
// one-cycle encrypt/decrypt start, waits for the core's ready (with timeout)
// and returns the 128-bit result as 4 words, MS word first.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : aes_host_bridge_if.slave (host streams + core signal set)
// Parameter TIMEOUT_CYC (2..1024): WAIT cycles allowed before the job is aborted.
module aes_host_bridge #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  aes_host_bridge_if.slave  bus
);

  localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_out_last;
  logic               r_new_en;
  logic               r_en;
  logic               r_err;
  logic               r_mode;
  logic [2:0]         r_word_idx;
  logic [1:0]         r_out_idx;
  logic [CNT_W-1:0]   r_tmo_cnt;
  logic [127:0]       r_key;
  logic [127:0]       r_data;
  logic [95:0]        r_rest;
  logic [31:0]        r_out_data;

  logic               w_accept;
  logic               w_core_rdy;
  logic               w_tmo_last;
  logic               w_out_hs;
  logic [127:0]       w_core_res;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; only the ready/result matching the latched mode is observed
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = bus.in_valid & r_in_ready;
    w_core_rdy  = r_mode ? bus.decipher_ready : bus.cipher_ready;
    w_core_res  = r_mode ? bus.plain_text_out : bus.cipher_text_out;
    w_tmo_last  = (r_tmo_cnt == CNT_LAST);
    w_out_hs    = r_out_valid & bus.out_ready;
    unique case (r_state)
      S_LOAD:  if (w_accept && (r_word_idx == 3'd7)) w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // a ready on the final timeout cycle still wins
        if (w_core_rdy)      w_state_nxt = S_DRAIN;
        else if (w_tmo_last) w_state_nxt = S_LOAD;
      end
      S_DRAIN: if (w_out_hs && (r_out_idx == 2'd3)) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Datapath and registered outputs, decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_new_en    <= 1'b0;
      r_en        <= 1'b0;
      r_err       <= 1'b0;
      r_mode      <= 1'b0;
      r_word_idx  <= '0;
      r_out_idx   <= '0;
      r_tmo_cnt   <= '0;
      r_key       <= '0;
      r_data      <= '0;
      r_rest      <= '0;
      r_out_data  <= '0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_LOAD);
      r_out_valid <= (w_state_nxt == S_DRAIN);
      r_new_en    <= (r_state == S_LOAD) && (w_state_nxt == S_START) && !r_mode;
      r_en        <= (r_state == S_LOAD) && (w_state_nxt == S_START) && r_mode;
      unique case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_word_idx <= r_word_idx + 3'd1;
            if (r_word_idx == 3'd0) r_mode <= bus.in_mode;
            // shift-in leaves word 0 in the top slot after four words
            if (!r_word_idx[2]) r_key  <= {r_key[95:0], bus.in_data};
            else                r_data <= {r_data[95:0], bus.in_data};
            // entering START: fresh timeout window and error flag
            if (r_word_idx == 3'd7) begin
              r_tmo_cnt <= '0;
              r_err     <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (w_core_rdy) begin
            r_out_data <= w_core_res[127:96];
            r_rest     <= w_core_res[95:0];
            r_out_idx  <= 2'd0;
          end else if (w_tmo_last) begin
            r_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (w_out_hs) begin
            r_out_idx  <= r_out_idx + 2'd1;
            r_out_data <= r_rest[95:64];
            r_rest     <= {r_rest[63:0], 32'h0};
            r_out_last <= (r_out_idx == 2'd2);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_data       = r_out_data;
  assign bus.out_last       = r_out_last;
  assign bus.err_timeout    = r_err;
  assign bus.plain_text_in  = r_data;
  assign bus.cipher_text_in = r_data;
  assign bus.cipher_key_in  = r_key;
  assign bus.round_key_10   = r_key;
  assign bus.cipher_new_en  = r_new_en;
  assign bus.EN             = r_en;

endmodule

// File: tb/tb_aes_host_bridge.sv
// Bench for aes_host_bridge: two instances (TIMEOUT_CYC 64 and 8) share all
// host and core inputs; a behavioural core model answers start pulses after
// a programmable latency with a bench-chosen result.
module tb_aes_host_bridge;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_mode = 1'b0;
  logic         out_ready = 1'b0;
  logic         cipher_ready = 1'b0;
  logic         decipher_ready = 1'b0;
  logic [127:0] ct_out = '0;
  logic [127:0] pt_out = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pulse_cyc = 0;
  int n_enc = 0;
  int n_dec = 0;
  int core_lat = 0;
  int core_wrong_at = 0;
  bit core_start_rdy = 1'b0;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_host_bridge_if ifa ();
  aes_host_bridge_if ifb ();

  assign ifa.in_valid = in_valid;        assign ifb.in_valid = in_valid;
  assign ifa.in_data = in_data;          assign ifb.in_data = in_data;
  assign ifa.in_mode = in_mode;          assign ifb.in_mode = in_mode;
  assign ifa.out_ready = out_ready;      assign ifb.out_ready = out_ready;
  assign ifa.cipher_text_out = ct_out;   assign ifb.cipher_text_out = ct_out;
  assign ifa.plain_text_out = pt_out;    assign ifb.plain_text_out = pt_out;
  assign ifa.cipher_ready = cipher_ready;     assign ifb.cipher_ready = cipher_ready;
  assign ifa.decipher_ready = decipher_ready; assign ifb.decipher_ready = decipher_ready;

  aes_host_bridge #(.TIMEOUT_CYC(64)) u_dut (.clk(clk), .reset(reset), .bus(ifa));
  aes_host_bridge #(.TIMEOUT_CYC(8))  u_dut_t8 (.clk(clk), .reset(reset), .bus(ifb));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Core model: selected ready core_lat cycles after a start pulse, optional
  // wrong-type ready at core_wrong_at, optional ready during the START cycle.
  int  lat_cnt = 0;
  int  wrong_cnt = 0;
  bit  cur_mode = 1'b0;
  always @(negedge clk) begin
    cipher_ready = 1'b0;
    decipher_ready = 1'b0;
    if (reset) begin
      lat_cnt = 0;
      wrong_cnt = 0;
    end
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        if (cur_mode) decipher_ready = 1'b1; else cipher_ready = 1'b1;
      end
    end
    if (wrong_cnt > 0) begin
      wrong_cnt--;
      if (wrong_cnt == 0) begin
        if (cur_mode) cipher_ready = 1'b1; else decipher_ready = 1'b1;
      end
    end
    if (ifa.cipher_new_en || ifa.EN) begin
      if (ifa.cipher_new_en) n_enc++;
      if (ifa.EN) n_dec++;
      pulse_cyc = cyc;
      cur_mode = ifa.EN;
      lat_cnt = core_lat;
      wrong_cnt = core_wrong_at;
      if (core_start_rdy) begin
        if (cur_mode) decipher_ready = 1'b1; else cipher_ready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_a_ctl"}, 128'({ifa.in_ready, ifa.out_valid, ifa.out_last,
        ifa.cipher_new_en, ifa.EN, ifa.err_timeout}), 128'(0));
    chk({tag, "_a_data"}, 128'(ifa.out_data), 128'(0));
    chk({tag, "_a_wide"}, ifa.plain_text_in | ifa.cipher_text_in |
        ifa.cipher_key_in | ifa.round_key_10, 128'(0));
    chk({tag, "_b_ctl"}, 128'({ifb.in_ready, ifb.out_valid, ifb.out_last,
        ifb.cipher_new_en, ifb.EN, ifb.err_timeout}), 128'(0));
    chk({tag, "_b_data"}, 128'(ifb.out_data), 128'(0));
  endtask

  // Sends nw job words; with a full job, returns at the START cycle
  task automatic load_job(input logic [127:0] key, input logic [127:0] data,
                          input logic mode, input bit gaps, input int nw);
    logic [127:0] src;
    for (int w = 0; w < nw; w++) begin
      int n;
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      src = (w < 4) ? key : data;
      in_data = src[127 - 32*(w % 4) -: 32];
      in_mode = (w == 0) ? mode : !mode;
      in_valid = 1'b1;
      n = 0;
      while (!ifa.in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) chk("in_ready_wait", 128'(ifa.in_ready), 128'(1));
      @(negedge clk);
      in_valid = 1'b0;
      in_data = $urandom;
    end
    if (nw == 8) begin
      chk("start_enc", 128'(ifa.cipher_new_en), 128'(!mode));
      chk("start_dec", 128'(ifa.EN), 128'(mode));
      chk("key_in", ifa.cipher_key_in, key);
      chk("rk10_in", ifa.round_key_10, key);
      chk("pt_in", ifa.plain_text_in, data);
      chk("ct_in", ifa.cipher_text_in, data);
    end
  endtask

  // Collects result words, checking order, last flag, hold under stall and latency
  task automatic collect(input logic [127:0] res, input bit bp, input int stop_after,
                         input bit check_b, input int exp_lat);
    int got = 0;
    int budget = 0;
    bit stall = 1'b0;
    bit first = 1'b1;
    logic [32:0] held = '0;
    logic [31:0] exp_w;
    while (got < stop_after && budget < 300) begin
      @(negedge clk);
      budget++;
      if (stall && ifa.out_valid) chk("out_hold", 128'({ifa.out_last, ifa.out_data}), 128'(held));
      out_ready = bp ? !out_ready : 1'b1;
      if (ifa.out_valid && first) begin
        if (exp_lat > 0) chk("out_latency", 128'(cyc - pulse_cyc), 128'(exp_lat + 1));
        first = 1'b0;
      end
      stall = ifa.out_valid && !out_ready;
      held = {ifa.out_last, ifa.out_data};
      if (ifa.out_valid && out_ready) begin
        exp_w = res[127 - 32*got -: 32];
        chk("out_word", 128'(ifa.out_data), 128'(exp_w));
        chk("out_last", 128'(ifa.out_last), 128'(got == 3));
        if (check_b) begin
          chk("b_out_word", 128'(ifb.out_data), 128'(exp_w));
          chk("b_out_valid", 128'(ifb.out_valid), 128'(1));
        end
        got++;
      end
    end
    if (got < stop_after) chk("out_count", 128'(got), 128'(stop_after));
    if (stop_after == 4) begin
      @(negedge clk);
      chk("post_in_ready", 128'(ifa.in_ready), 128'(1));
      chk("post_out_valid", 128'(ifa.out_valid), 128'(0));
    end
  endtask

  task automatic job(input logic [127:0] key, input logic [127:0] data, input logic mode,
                     input logic [127:0] res, input bit gaps, input bit bp, input bit check_b);
    int e0 = n_enc;
    int d0 = n_dec;
    ct_out = mode ? ~res : res;
    pt_out = mode ? res : ~res;
    load_job(key, data, mode, gaps, 8);
    collect(res, bp, 4, check_b, core_lat);
    chk("enc_pulses", 128'(n_enc - e0), 128'(!mode));
    chk("dec_pulses", 128'(n_dec - d0), 128'(mode));
  endtask

  initial begin
    logic [127:0] k, d, r;
    logic m;
    bit saw_ov;
    int n;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rel_in_ready", 128'(ifa.in_ready), 128'(1));

    // known-answer encrypt and decrypt
    core_lat = 10;
    job(K1, D1, 1'b0, C1, 1'b0, 1'b0, 1'b0);
    core_lat = 6;
    job(K2, C1, 1'b1, D1, 1'b0, 1'b0, 1'b1);

    // same vectors under input gaps and toggling out_ready
    core_lat = 7;
    job(K1, D1, 1'b0, C1, 1'b1, 1'b1, 1'b1);
    job(K2, C1, 1'b1, D1, 1'b1, 1'b1, 1'b1);

    // random jobs
    for (int j = 0; j < 6; j++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
      r = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      core_lat = $urandom_range(1, 7);
      job(k, d, m, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // timeout: core silent apart from a ready during START
    core_lat = 0;
    core_start_rdy = 1'b1;
    ct_out = C1;
    load_job(K1, D1, 1'b0, 1'b0, 8);
    saw_ov = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      saw_ov |= ifa.out_valid | ifb.out_valid;
      if (i == 8) chk("tmo_err_early", 128'(ifb.err_timeout), 128'(0));
      if (i == 9) begin
        chk("tmo_err_set", 128'(ifb.err_timeout), 128'(1));
        chk("tmo_in_ready", 128'(ifb.in_ready), 128'(1));
      end
    end
    n = 0;
    while (!ifa.in_ready && n < 100) begin
      @(negedge clk);
      n++;
      saw_ov |= ifa.out_valid | ifb.out_valid;
    end
    chk("tmo_a_in_ready", 128'(ifa.in_ready), 128'(1));
    chk("tmo_a_err", 128'(ifa.err_timeout), 128'(1));
    chk("tmo_no_out", 128'(saw_ov), 128'(0));
    core_start_rdy = 1'b0;

    // next job clears the flag
    core_lat = 5;
    ct_out = C1;
    pt_out = ~C1;
    load_job(K1, D1, 1'b0, 1'b0, 8);
    @(negedge clk);
    chk("tmo_clr_b", 128'(ifb.err_timeout), 128'(0));
    chk("tmo_clr_a", 128'(ifa.err_timeout), 128'(0));
    collect(C1, 1'b0, 4, 1'b1, 5);

    // wrong-type ready early, selected ready on the last timeout cycle of the 8-cycle instance
    core_lat = 8;
    core_wrong_at = 3;
    r = {$urandom, $urandom, $urandom, $urandom};
    job(K1, D1, 1'b0, r, 1'b0, 1'b0, 1'b1);
    chk("coll_b_err", 128'(ifb.err_timeout), 128'(0));
    chk("coll_a_err", 128'(ifa.err_timeout), 128'(0));
    core_wrong_at = 0;

    // reset after 5 words
    load_job(K2, C1, 1'b1, 1'b0, 5);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_part");
    reset = 1'b0;
    @(negedge clk);
    chk("rst_part_in_ready", 128'(ifa.in_ready), 128'(1));
    core_lat = 3;
    job(K2, C1, 1'b1, D1, 1'b0, 1'b0, 1'b1);

    // reset in DRAIN after two words
    core_lat = 4;
    r = {$urandom, $urandom, $urandom, $urandom};
    ct_out = r;
    pt_out = ~r;
    load_job(K1, D1, 1'b0, 1'b0, 8);
    collect(r, 1'b0, 2, 1'b1, 4);
    reset = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_drain");
    reset = 1'b0;
    @(negedge clk);
    chk("rst_drain_in_ready", 128'(ifa.in_ready), 128'(1));
    job(K1, D1, 1'b0, C1, 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
